rs_ooo_station: RTL and testbench
=================================

Name: rs_ooo_station

Overview:
- Parametrised successor to the in-order FIFO reservation station.
- Holds up to DEPTH renamed instructions and accepts up to WR_PORTS writes per cycle.
- Snoops one common data bus (CDB) to wake up pending operands.
- Issues the oldest fully-ready entry out of order into a registered issue slot; flushes wrong-path entries by branch tag.

Parameters:
- DATA_WIDTH, 32, operand data width
- TAG_WIDTH, 6, rename/producer tag width
- PAYLOAD_WIDTH, 64, opaque opcode/dest payload carried to the FU
- BTAG_WIDTH, 32, branch tag width
- DEPTH, 8, entry count (≥2)
- WR_PORTS, 4, write lanes per cycle (1..4); lane 0 is oldest in program order

Ports:
- RSCLK  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- RSWE  in  WR_PORTS  per-lane write enable
- RSInPayload  in  WR_PORTS*PAYLOAD_WIDTH  lane payloads, lane i at [i*W +: W]
- RSInFlagA, RSInFlagB  in  WR_PORTS each  1 = operand data already valid
- RSInTagA, RSInTagB  in  WR_PORTS*TAG_WIDTH each  producer tags
- RSInDataA, RSInDataB  in  WR_PORTS*DATA_WIDTH each  operand data
- RSInBranchTag  in  WR_PORTS*BTAG_WIDTH  branch tag of each instruction
- CDBValid  in  1  broadcast valid
- CDBTag  in  TAG_WIDTH  broadcast tag
- CDBData  in  DATA_WIDTH  broadcast data
- Branch  in  1  mispredict flush strobe
- BranchTag  in  BTAG_WIDTH  tag to squash
- IssueReady  in  1  FU accepts the issue register this cycle
- RSIssueValid  out  1  issue register holds an instruction
- RSIssuePayload  out  PAYLOAD_WIDTH  issued payload
- RSIssueDataA, RSIssueDataB  out  DATA_WIDTH each  issued operands
- RSBufEmpty  out  1  no stored entries
- RSBufFull  out  1  RSBufCounter == DEPTH
- RSBufCounter  out  $clog2(DEPTH+1)  stored entries (excludes issue register)
- RSWrOverflow  out  1  one-cycle pulse: write group rejected

Behaviour:
- Reset low (async): all entries invalid, RSIssueValid=0, all issue data/payload = 0, RSBufCounter=0, RSBufEmpty=1, RSBufFull=0, RSWrOverflow=0.
- Reset asserted mid-operation discards everything, including the issue register.
- Storage: age-ordered collapsing queue. Slot 0 is oldest; valid slots are contiguous from 0.
- Write acceptance: group accepted iff popcount(RSWE) ≤ DEPTH − RSBufCounter (registered count; same-cycle frees are not credited).
  - Else the whole group is dropped and RSWrOverflow=1 next cycle.
  - Accepted lanes append in lane order after the surviving/compacted entries.
  - Non-contiguous RSWE is legal; disabled lanes leave no gap.
- Wakeup: when CDBValid=1, every stored entry with FlagX=0 and TagX==CDBTag sets FlagX=1 and DataX=CDBData at the edge.
  - Lanes being written in the same cycle with FlagX=0 and a matching tag also capture CDBData, so no wakeup is lost.
- Ready = FlagA & FlagB, with the same-cycle CDB match counted as ready (forwarding).
- Issue: when !RSIssueValid | IssueReady, the lowest-index ready, non-flushed slot loads the issue register at the edge and is removed; slots above shift down.
  - If a forwarded operand is used, the issue register captures CDBData.
  - If nothing is ready, RSIssueValid goes to 0 (or stays 0).
  - If RSIssueValid & !IssueReady, the issue register holds and no selection occurs.
- Latency: a lane written ready at edge k is stored at edge k and earliest in the issue register at edge k+1.
  - No write-to-issue bypass.
- Flush: Branch=1 at an edge removes, in that same edge:
  - all stored entries with BranchTag match;
  - incoming lanes with a match;
  - the issue register if its stored branch tag matches (RSIssueValid→0, unless reloaded from a surviving entry when IssueReady or it was empty).
  - Flushed entries are never selected. Survivors compact preserving age.
- Simultaneous flush + issue + write + wakeup in one cycle: evaluation order is flush, then wakeup, then select/remove, then compact, then append.
  - Acceptance is still decided on the old count.
- RSBufCounter = old − issued − flushed + accepted. It never exceeds DEPTH and never underflows.

Test Plan:
- Reset low, then high; write 4 lanes all ready with payloads 1..4 → RSBufCounter=4 after edge 1; issue 1,2,3,4 on consecutive cycles with IssueReady=1; RSBufEmpty=1 after the last issue.
- Fill 8 entries with FlagA=0 TagA=5, then write 1 more lane → RSWrOverflow pulses, RSBufCounter stays 8, RSBufFull=1.
- Entry 0 waits on tag 3, entry 1 is ready → entry 1 issues first (out of order). Then CDBValid=1, CDBTag=3, CDBData=0xDEAD → entry 0 issues in that cycle's edge with RSIssueDataA=0xDEAD.
- Write lane with FlagB=0 TagB=7 in the same cycle as CDB tag 7 data 0x55 → entry stored ready with DataB=0x55; issues next edge.
- 6 entries with branch tags A,B,A,B,A,B; Branch=1 BranchTag=A → RSBufCounter=3; remaining issue in order B,B,B. Issue register holding tag A with IssueReady=0 is squashed.
- RSIssueValid=1, IssueReady=0 for 3 cycles → issue outputs are stable, no entry is removed. Assert Reset low mid-stall → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/rs_ooo_station.sv
`default_nettype none
// ============================================================================
//  Module   : rs_ooo_station
//  Purpose  : Out-of-order reservation station. Holds up to DEPTH renamed
//             instructions in an age-ordered collapsing queue (slot 0 is the
//             oldest), accepts up to WR_PORTS writes per cycle, snoops one CDB
//             to wake pending operands, and issues the oldest fully-ready
//             entry into a registered issue slot. Wrong-path entries are
//             squashed by branch tag.
//  Ports    :
//    RSCLK / Reset            clock (rising edge) / async active-low reset
//    RSWE, RSIn*              per-lane write group (lane 0 oldest)
//    CDBValid/Tag/Data        common data bus broadcast
//    Branch, BranchTag        mispredict flush strobe and tag
//    IssueReady               FU accepts the issue register this cycle
//    RSIssueValid/Payload/DataA/DataB   registered issue slot
//    RSBufEmpty/Full/Counter  stored-entry occupancy (issue slot excluded)
//    RSWrOverflow             one-cycle pulse: a write group was rejected
//  Revision : 1.0  initial release
// ============================================================================
module rs_ooo_station #(
    parameter int DATA_WIDTH    = 32,
    parameter int TAG_WIDTH     = 6,
    parameter int PAYLOAD_WIDTH = 64,
    parameter int BTAG_WIDTH    = 32,
    parameter int DEPTH         = 8,
    parameter int WR_PORTS      = 4
) (
    input  logic                              RSCLK,
    input  logic                              Reset,
    input  logic [WR_PORTS-1:0]               RSWE,
    input  logic [WR_PORTS*PAYLOAD_WIDTH-1:0] RSInPayload,
    input  logic [WR_PORTS-1:0]               RSInFlagA,
    input  logic [WR_PORTS-1:0]               RSInFlagB,
    input  logic [WR_PORTS*TAG_WIDTH-1:0]     RSInTagA,
    input  logic [WR_PORTS*TAG_WIDTH-1:0]     RSInTagB,
    input  logic [WR_PORTS*DATA_WIDTH-1:0]    RSInDataA,
    input  logic [WR_PORTS*DATA_WIDTH-1:0]    RSInDataB,
    input  logic [WR_PORTS*BTAG_WIDTH-1:0]    RSInBranchTag,
    input  logic                              CDBValid,
    input  logic [TAG_WIDTH-1:0]              CDBTag,
    input  logic [DATA_WIDTH-1:0]             CDBData,
    input  logic                              Branch,
    input  logic [BTAG_WIDTH-1:0]             BranchTag,
    input  logic                              IssueReady,
    output logic                              RSIssueValid,
    output logic [PAYLOAD_WIDTH-1:0]          RSIssuePayload,
    output logic [DATA_WIDTH-1:0]             RSIssueDataA,
    output logic [DATA_WIDTH-1:0]             RSIssueDataB,
    output logic                              RSBufEmpty,
    output logic                              RSBufFull,
    output logic [$clog2(DEPTH+1)-1:0]        RSBufCounter,
    output logic                              RSWrOverflow
);

    localparam int CW = $clog2(DEPTH + 1);
    // Wide enough for DEPTH plus a full write group without wrapping.
    localparam int SW = $clog2(DEPTH + WR_PORTS + 1);

    typedef struct packed {
        logic [PAYLOAD_WIDTH-1:0] payload;
        logic                     fa;
        logic                     fb;
        logic [TAG_WIDTH-1:0]     ta;
        logic [TAG_WIDTH-1:0]     tb;
        logic [DATA_WIDTH-1:0]    da;
        logic [DATA_WIDTH-1:0]    db;
        logic [BTAG_WIDTH-1:0]    btag;
    } entry_t;

    // Stored state
    entry_t                   ent_q [DEPTH];
    logic [DEPTH-1:0]         vld_q;
    logic [CW-1:0]            cnt_q;
    logic                     ovf_q;
    logic                     iss_vld_q;
    logic [PAYLOAD_WIDTH-1:0] iss_payload_q;
    logic [DATA_WIDTH-1:0]    iss_da_q;
    logic [DATA_WIDTH-1:0]    iss_db_q;
    logic [BTAG_WIDTH-1:0]    iss_btag_q;

    // Per-cycle evaluation
    entry_t                   woke      [DEPTH];
    entry_t                   lane_woke [WR_PORTS];
    logic [DEPTH-1:0]         kill;
    logic [DEPTH-1:0]         ready;
    logic [DEPTH-1:0]         sel_onehot;
    logic [WR_PORTS-1:0]      lane_store;
    logic                     issue_en;
    logic                     any_sel;
    logic                     accept;
    logic [SW-1:0]            wr_cnt;
    logic [SW-1:0]            free_slots;
    logic [PAYLOAD_WIDTH-1:0] sel_payload;
    logic [DATA_WIDTH-1:0]    sel_da;
    logic [DATA_WIDTH-1:0]    sel_db;
    logic [BTAG_WIDTH-1:0]    sel_btag;
    entry_t                   nxt_ent [DEPTH];
    logic [DEPTH-1:0]         nxt_vld;
    logic [CW-1:0]            nxt_cnt;

    // Flush and wakeup of stored entries. The woken copy is what gets
    // selected or compacted, so a same-cycle CDB match acts as forwarding.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = ent_q[i];
            if (CDBValid && !ent_q[i].fa && (ent_q[i].ta == CDBTag)) begin
                woke[i].fa = 1'b1;
                woke[i].da = CDBData;
            end
            if (CDBValid && !ent_q[i].fb && (ent_q[i].tb == CDBTag)) begin
                woke[i].fb = 1'b1;
                woke[i].db = CDBData;
            end
            kill[i]  = vld_q[i] && Branch && (ent_q[i].btag == BranchTag);
            ready[i] = vld_q[i] && !kill[i] && woke[i].fa && woke[i].fb;
        end
    end

    // Incoming lanes: same wakeup so a broadcast in the write cycle is not lost.
    always_comb begin
        wr_cnt = '0;
        for (int l = 0; l < WR_PORTS; l++) begin
            lane_woke[l].payload = RSInPayload[l*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
            lane_woke[l].ta      = RSInTagA[l*TAG_WIDTH +: TAG_WIDTH];
            lane_woke[l].tb      = RSInTagB[l*TAG_WIDTH +: TAG_WIDTH];
            lane_woke[l].btag    = RSInBranchTag[l*BTAG_WIDTH +: BTAG_WIDTH];
            lane_woke[l].fa      = RSInFlagA[l];
            lane_woke[l].fb      = RSInFlagB[l];
            lane_woke[l].da      = RSInDataA[l*DATA_WIDTH +: DATA_WIDTH];
            lane_woke[l].db      = RSInDataB[l*DATA_WIDTH +: DATA_WIDTH];
            if (CDBValid && !RSInFlagA[l] && (lane_woke[l].ta == CDBTag)) begin
                lane_woke[l].fa = 1'b1;
                lane_woke[l].da = CDBData;
            end
            if (CDBValid && !RSInFlagB[l] && (lane_woke[l].tb == CDBTag)) begin
                lane_woke[l].fb = 1'b1;
                lane_woke[l].db = CDBData;
            end
            wr_cnt = wr_cnt + SW'(RSWE[l]);
        end
    end

    // Acceptance uses the registered count only; frees in this cycle are
    // deliberately not credited so the decision has no path through select.
    always_comb begin
        free_slots = SW'(DEPTH) - SW'(cnt_q);
        accept     = (wr_cnt <= free_slots);
        for (int l = 0; l < WR_PORTS; l++) begin
            lane_store[l] = accept && RSWE[l] &&
                            !(Branch && (lane_woke[l].btag == BranchTag));
        end
    end

    // Oldest-ready selection. No selection while the issue slot is stalled.
    always_comb begin
        issue_en    = !iss_vld_q || IssueReady;
        sel_onehot  = '0;
        any_sel     = 1'b0;
        sel_payload = '0;
        sel_da      = '0;
        sel_db      = '0;
        sel_btag    = '0;
        if (issue_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ready[i] && !any_sel) begin
                    any_sel       = 1'b1;
                    sel_onehot[i] = 1'b1;
                    sel_payload   = woke[i].payload;
                    sel_da        = woke[i].da;
                    sel_db        = woke[i].db;
                    sel_btag      = woke[i].btag;
                end
            end
        end
    end

    // Compact survivors toward slot 0 in age order, then append stored lanes.
    always_comb begin
        logic [SW-1:0] rank;
        rank    = '0;
        nxt_vld = '0;
        for (int j = 0; j < DEPTH; j++) begin
            nxt_ent[j] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && !kill[i] && !sel_onehot[i]) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (rank == SW'(j)) begin
                        nxt_ent[j] = woke[i];
                        nxt_vld[j] = 1'b1;
                    end
                end
                rank = rank + SW'(1);
            end
        end
        for (int l = 0; l < WR_PORTS; l++) begin
            if (lane_store[l]) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (rank == SW'(j)) begin
                        nxt_ent[j] = lane_woke[l];
                        nxt_vld[j] = 1'b1;
                    end
                end
                rank = rank + SW'(1);
            end
        end
        nxt_cnt = CW'(rank);
    end

    always_ff @(posedge RSCLK or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            vld_q         <= '0;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            iss_vld_q     <= 1'b0;
            iss_payload_q <= '0;
            iss_da_q      <= '0;
            iss_db_q      <= '0;
            iss_btag_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= nxt_ent[i];
            end
            vld_q <= nxt_vld;
            cnt_q <= nxt_cnt;
            ovf_q <= !accept;
            if (issue_en) begin
                iss_vld_q <= any_sel;
                if (any_sel) begin
                    iss_payload_q <= sel_payload;
                    iss_da_q      <= sel_da;
                    iss_db_q      <= sel_db;
                    iss_btag_q    <= sel_btag;
                end
            end else if (Branch && (iss_btag_q == BranchTag)) begin
                // Stalled slot holding a wrong-path instruction.
                iss_vld_q <= 1'b0;
            end
        end
    end

    assign RSIssueValid   = iss_vld_q;
    assign RSIssuePayload = iss_payload_q;
    assign RSIssueDataA   = iss_da_q;
    assign RSIssueDataB   = iss_db_q;
    assign RSBufCounter   = cnt_q;
    assign RSBufEmpty     = (cnt_q == '0);
    assign RSBufFull      = (cnt_q == CW'(DEPTH));
    assign RSWrOverflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_rs_ooo_station.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rs_ooo_station
//  Purpose  : Scoreboard bench for rs_ooo_station. Stimulus pushes the
//             expected issue stream; a negedge monitor pops and compares on
//             every issue handshake. Occupancy/flag checks are directed.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rs_ooo_station;

    localparam int DW = 32;
    localparam int TW = 6;
    localparam int PW = 64;
    localparam int BW = 32;
    localparam int DEPTH = 8;
    localparam int WP = 4;
    localparam int CW = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [WP-1:0]     RSWE;
    logic [WP*PW-1:0]  RSInPayload;
    logic [WP-1:0]     RSInFlagA, RSInFlagB;
    logic [WP*TW-1:0]  RSInTagA, RSInTagB;
    logic [WP*DW-1:0]  RSInDataA, RSInDataB;
    logic [WP*BW-1:0]  RSInBranchTag;
    logic              CDBValid;
    logic [TW-1:0]     CDBTag;
    logic [DW-1:0]     CDBData;
    logic              Branch;
    logic [BW-1:0]     BranchTag;
    logic              IssueReady;
    logic              RSIssueValid;
    logic [PW-1:0]     RSIssuePayload;
    logic [DW-1:0]     RSIssueDataA, RSIssueDataB;
    logic              RSBufEmpty, RSBufFull, RSWrOverflow;
    logic [CW-1:0]     RSBufCounter;

    rs_ooo_station #(
        .DATA_WIDTH(DW), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW),
        .BTAG_WIDTH(BW), .DEPTH(DEPTH), .WR_PORTS(WP)
    ) dut (
        .RSCLK(clk), .Reset(rst_n),
        .RSWE(RSWE), .RSInPayload(RSInPayload),
        .RSInFlagA(RSInFlagA), .RSInFlagB(RSInFlagB),
        .RSInTagA(RSInTagA), .RSInTagB(RSInTagB),
        .RSInDataA(RSInDataA), .RSInDataB(RSInDataB),
        .RSInBranchTag(RSInBranchTag),
        .CDBValid(CDBValid), .CDBTag(CDBTag), .CDBData(CDBData),
        .Branch(Branch), .BranchTag(BranchTag), .IssueReady(IssueReady),
        .RSIssueValid(RSIssueValid), .RSIssuePayload(RSIssuePayload),
        .RSIssueDataA(RSIssueDataA), .RSIssueDataB(RSIssueDataB),
        .RSBufEmpty(RSBufEmpty), .RSBufFull(RSBufFull),
        .RSBufCounter(RSBufCounter), .RSWrOverflow(RSWrOverflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] p;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [BW-1:0] TAG_A = 32'hA;
    localparam logic [BW-1:0] TAG_B = 32'hB;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic push(input logic [PW-1:0] p, input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        e.p = p; e.a = a; e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        RSWE = '0; RSInPayload = '0; RSInFlagA = '0; RSInFlagB = '0;
        RSInTagA = '0; RSInTagB = '0; RSInDataA = '0; RSInDataB = '0;
        RSInBranchTag = '0; CDBValid = 1'b0; CDBTag = '0; CDBData = '0;
        Branch = 1'b0; BranchTag = '0;
    endtask

    task automatic set_lane(input int l, input logic [PW-1:0] p,
                            input logic fa, input logic [TW-1:0] ta, input logic [DW-1:0] da,
                            input logic fb, input logic [TW-1:0] tb, input logic [DW-1:0] db,
                            input logic [BW-1:0] bt);
        RSWE[l] = 1'b1;
        RSInPayload[l*PW +: PW]   = p;
        RSInFlagA[l] = fa;  RSInTagA[l*TW +: TW] = ta;  RSInDataA[l*DW +: DW] = da;
        RSInFlagB[l] = fb;  RSInTagB[l*TW +: TW] = tb;  RSInDataB[l*DW +: DW] = db;
        RSInBranchTag[l*BW +: BW] = bt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        logic done;
        done = 1'b0;
        IssueReady = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            step();
            done = RSBufEmpty && !RSIssueValid && (exp_q.size() == 0);
        end
        chk(name, {63'd0, done}, 64'd1);
    endtask

    // Scoreboard monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && RSIssueValid && IssueReady) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_issue actual_payload=%0h expected=none", RSIssuePayload);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (RSIssuePayload !== e.p || RSIssueDataA !== e.a || RSIssueDataB !== e.b) begin
                    failures++;
                    $display("FAIL issue actual=%0h/%0h/%0h expected=%0h/%0h/%0h",
                             RSIssuePayload, RSIssueDataA, RSIssueDataB, e.p, e.a, e.b);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        IssueReady = 1'b0;
        step(); step();
        chk("rst_valid", {63'd0, RSIssueValid}, 64'd0);
        chk("rst_cnt",   64'(RSBufCounter), 64'd0);
        chk("rst_empty", {63'd0, RSBufEmpty}, 64'd1);
        chk("rst_full",  {63'd0, RSBufFull}, 64'd0);
        chk("rst_ovf",   {63'd0, RSWrOverflow}, 64'd0);
        rst_n = 1'b1;
        step();

        // 1: four ready lanes, issued in order on consecutive cycles
        IssueReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_lane(i, 64'(i + 1), 1'b1, '0, 32'h10 + 32'(i), 1'b1, '0, 32'h20 + 32'(i), 32'h0);
            push(64'(i + 1), 32'h10 + 32'(i), 32'h20 + 32'(i));
        end
        step(); idle();
        chk("t1_cnt4", 64'(RSBufCounter), 64'd4);
        step(); chk("t1_cnt3", 64'(RSBufCounter), 64'd3);
        step(); chk("t1_cnt2", 64'(RSBufCounter), 64'd2);
        step(); chk("t1_cnt1", 64'(RSBufCounter), 64'd1);
        step(); chk("t1_cnt0", 64'(RSBufCounter), 64'd0);
        chk("t1_empty", {63'd0, RSBufEmpty}, 64'd1);
        step(); chk("t1_valid_off", {63'd0, RSIssueValid}, 64'd0);

        // 2: fill with entries waiting on tag 5, then overflow
        IssueReady = 1'b0;
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 4; i++)
                set_lane(i, 64'(100 + g*4 + i), 1'b0, 6'd5, '0, 1'b1, '0, 32'h30, 32'h0);
            step(); idle();
        end
        chk("t2_cnt8", 64'(RSBufCounter), 64'd8);
        chk("t2_full", {63'd0, RSBufFull}, 64'd1);
        set_lane(2, 64'd200, 1'b1, '0, 32'h1, 1'b1, '0, 32'h2, 32'h0);
        step(); idle();
        chk("t2_ovf", {63'd0, RSWrOverflow}, 64'd1);
        chk("t2_cnt_hold", 64'(RSBufCounter), 64'd8);
        chk("t2_full_hold", {63'd0, RSBufFull}, 64'd1);
        step();
        chk("t2_ovf_pulse", {63'd0, RSWrOverflow}, 64'd0);
        for (int i = 0; i < 8; i++) push(64'(100 + i), 32'h77, 32'h30);
        IssueReady = 1'b1;
        CDBValid = 1'b1; CDBTag = 6'd5; CDBData = 32'h77;
        step(); idle();
        chk("t2_cnt7", 64'(RSBufCounter), 64'd7);
        drain("t2_drain");

        // 3: out-of-order issue, then CDB-forwarded issue
        set_lane(0, 64'd300, 1'b0, 6'd3, '0, 1'b1, '0, 32'h31, 32'h0);
        set_lane(1, 64'd301, 1'b1, '0, 32'h41, 1'b1, '0, 32'h42, 32'h0);
        push(64'd301, 32'h41, 32'h42);
        push(64'd300, 32'hDEAD, 32'h31);
        step(); idle();
        step();
        chk("t3_ooo_payload", RSIssuePayload, 64'd301);
        chk("t3_cnt1", 64'(RSBufCounter), 64'd1);
        CDBValid = 1'b1; CDBTag = 6'd3; CDBData = 32'hDEAD;
        step(); idle();
        chk("t3_fwd_payload", RSIssuePayload, 64'd300);
        chk("t3_fwd_dataA", 64'(RSIssueDataA), 64'hDEAD);
        drain("t3_drain");

        // 4: write-cycle wakeup on lane 2 (lanes 0,1 disabled)
        set_lane(2, 64'd400, 1'b1, '0, 32'h11, 1'b0, 6'd7, '0, 32'h0);
        CDBValid = 1'b1; CDBTag = 6'd7; CDBData = 32'h55;
        push(64'd400, 32'h11, 32'h55);
        step(); idle();
        chk("t4_cnt1", 64'(RSBufCounter), 64'd1);
        step();
        chk("t4_valid", {63'd0, RSIssueValid}, 64'd1);
        chk("t4_dataB", 64'(RSIssueDataB), 64'h55);
        drain("t4_drain");

        // 5: branch flush of tag A, including a stalled issue slot and a lane
        IssueReady = 1'b0;
        set_lane(0, 64'd500, 1'b1, '0, 32'h5, 1'b1, '0, 32'h6, TAG_A);
        step(); idle();
        step();
        chk("t5_slot_loaded", RSIssuePayload, 64'd500);
        for (int i = 0; i < 4; i++)
            set_lane(i, 64'(510 + i), 1'b1, '0, 32'(i), 1'b1, '0, 32'(i), (i % 2 == 0) ? TAG_A : TAG_B);
        step(); idle();
        set_lane(0, 64'd514, 1'b1, '0, 32'd4, 1'b1, '0, 32'd4, TAG_A);
        set_lane(1, 64'd515, 1'b1, '0, 32'd5, 1'b1, '0, 32'd5, TAG_B);
        step(); idle();
        chk("t5_cnt6", 64'(RSBufCounter), 64'd6);
        push(64'd511, 32'd1, 32'd1);
        push(64'd513, 32'd3, 32'd3);
        push(64'd515, 32'd5, 32'd5);
        push(64'd521, 32'h21, 32'h22);
        Branch = 1'b1; BranchTag = TAG_A;
        set_lane(0, 64'd520, 1'b1, '0, 32'h20, 1'b1, '0, 32'h20, TAG_A);
        set_lane(1, 64'd521, 1'b1, '0, 32'h21, 1'b1, '0, 32'h22, TAG_B);
        step(); idle();
        chk("t5_cnt_after_flush", 64'(RSBufCounter), 64'd4);
        chk("t5_slot_squashed", {63'd0, RSIssueValid}, 64'd0);
        drain("t5_drain");

        // 6: stall for 3 cycles, then async reset mid-stall
        IssueReady = 1'b0;
        set_lane(0, 64'd600, 1'b1, '0, 32'h60, 1'b1, '0, 32'h61, 32'h0);
        set_lane(1, 64'd601, 1'b1, '0, 32'h62, 1'b1, '0, 32'h63, 32'h0);
        step(); idle();
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t6_stall_valid", {63'd0, RSIssueValid}, 64'd1);
            chk("t6_stall_payload", RSIssuePayload, 64'd600);
            chk("t6_stall_dataA", 64'(RSIssueDataA), 64'h60);
            chk("t6_stall_cnt", 64'(RSBufCounter), 64'd1);
        end
        #3 rst_n = 1'b0;
        #1;
        chk("t6_arst_valid", {63'd0, RSIssueValid}, 64'd0);
        chk("t6_arst_payload", RSIssuePayload, 64'd0);
        chk("t6_arst_dataA", 64'(RSIssueDataA), 64'd0);
        chk("t6_arst_dataB", 64'(RSIssueDataB), 64'd0);
        chk("t6_arst_cnt", 64'(RSBufCounter), 64'd0);
        chk("t6_arst_empty", {63'd0, RSBufEmpty}, 64'd1);
        chk("t6_arst_full", {63'd0, RSBufFull}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
